peripheral_uart_rx: RTL and testbench

- UART receiver peripheral on the J1 I/O bus; complements the transmit-side peripheral_uart.
- Samples serial input uart_rx at 16x baud and assembles 8N1 frames (LSB first).
- Holds received bytes for the CPU with valid, frame-error and overrun status.
- Bus handshake matches peripheral_uart: cs/rd/wr strobes, 4-bit addr from j1_io_addr LSBs, 16-bit data.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/peripheral_uart_rx_if.sv | 20 ++
 rtl/uart_rx_core.sv | 118 +++++++++++
 rtl/peripheral_uart_rx.sv | 129 ++++++++++++
 tb/tb_peripheral_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: register map, STATUS bit positions,
// receiver FSM encoding and frame geometry.
package uart_pkg;

  localparam logic [3:0] UART_ADDR_DATA   = 4'h0;
  localparam logic [3:0] UART_ADDR_STATUS = 4'h2;

  localparam int ST_VALID = 0;
  localparam int ST_FERR  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_CNT   = 4;

  localparam int DATA_BITS = 8;
  localparam int OVS       = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/peripheral_uart_rx_if.sv
// J1 I/O bus bundle for the UART receiver.
// master = CPU side (strobes, addr, d_in), slave = peripheral (d_out).
interface peripheral_uart_rx_if;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;

  modport master (
    output d_in, cs, addr, rd, wr,
    input  d_out
  );

  modport slave (
    input  d_in, cs, addr, rd, wr,
    output d_out
  );
endinterface

// File: rtl/uart_rx_core.sv
// Serial front end: 2-FF sync, 16x tick generator, 8N1 FSM, shifter.
// Ports: clk, rst, uart_rx in; byte_strobe, rx_byte, frame_err_strobe, busy out.
module uart_rx_core #(
  parameter int DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       frame_err_strobe,
  output logic       busy
);
  import uart_pkg::*;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [3:0] MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVS - 1);
  localparam logic [2:0] BMAX = 3'(DATA_BITS - 1);

  logic          s1, s2, line_d;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          tick;

  assign tick    = (cnt == DIV_M1);
  assign rx_byte = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      line_d <= 1'b1;
    end else begin
      s1     <= uart_rx;
      s2     <= s1;
      line_d <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RX_IDLE;
      cnt              <= '0;
      tcnt             <= '0;
      bcnt             <= '0;
      shreg            <= '0;
      busy             <= 1'b0;
      byte_strobe      <= 1'b0;
      frame_err_strobe <= 1'b0;
    end else begin
      byte_strobe      <= 1'b0;
      frame_err_strobe <= 1'b0;
      if (state == RX_IDLE) cnt <= '0;
      else if (tick)        cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      unique case (state)
        RX_IDLE: begin
          if (line_d && !s2) begin
            state <= RX_START;
            tcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (tick) begin
            if (tcnt == MID) begin
              tcnt <= '0;
              bcnt <= '0;
              if (!s2) begin
                state <= RX_DATA;
              end else begin
                state <= RX_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (tcnt == LAST) begin
              tcnt  <= '0;
              shreg <= {s2, shreg[7:1]};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == BMAX) state <= RX_STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (tcnt == LAST) begin
              tcnt  <= '0;
              state <= RX_IDLE;
              busy  <= 1'b0;
              if (s2) byte_strobe      <= 1'b1;
              else    frame_err_strobe <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= RX_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART receive peripheral: bus decode, holding register/FIFO, status.
// Ports: clk, rst, bus (slave), uart_rx in, rx_irq out. Option: UART_RX_FIFO_EN.
module peripheral_uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int OVS      = 16,
  parameter int DIV      = CLK_FREQ / (BAUD * OVS)
) (
  input  logic                  clk,
  input  logic                  rst,
  peripheral_uart_rx_if.slave   bus,
  input  logic                  uart_rx,
  output logic                  rx_irq
);
  import uart_pkg::*;

  logic        byte_strobe, ferr_strobe, busy;
  logic [7:0]  rx_byte;
  logic        rd_en, wr_en, pop, clr;
  logic        valid, ovr, ferr, ovr_set;
  logic [2:0]  cnt;
  logic [15:0] rd_data, status;
  logic        unused_din;

  uart_rx_core #(.DIV(DIV)) u_core (
    .clk              (clk),
    .rst              (rst),
    .uart_rx          (uart_rx),
    .byte_strobe      (byte_strobe),
    .rx_byte          (rx_byte),
    .frame_err_strobe (ferr_strobe),
    .busy             (busy)
  );

  // a read on the same edge as a write wins; the write is dropped
  assign rd_en = bus.cs & bus.rd;
  assign wr_en = bus.cs & bus.wr & ~bus.rd;
  assign pop   = rd_en & (bus.addr == UART_ADDR_DATA);
  assign clr   = wr_en & (bus.addr == UART_ADDR_STATUS);
  assign unused_din = ^{bus.d_in[15:3], bus.d_in[0]};

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] rp, wp;
  logic [2:0] count, count_nxt;
  logic       pop_eff, push;

  // a pop on a full FIFO frees the slot for the arriving byte
  assign pop_eff   = pop & (count != 3'd0);
  assign push      = byte_strobe & ((count != 3'd4) | pop_eff);
  assign ovr_set   = byte_strobe & ~push;
  assign count_nxt = count + {2'b00, push} - {2'b00, pop_eff};
  assign rd_data   = (count != 3'd0) ? {8'h00, mem[rp]} : 16'h0000;
  assign cnt       = count;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (push)    wp <= wp + 1'b1;
      if (pop_eff) rp <= rp + 1'b1;
      count <= count_nxt;
      valid <= (count_nxt != 3'd0);
    end
  end
`else
  logic [7:0] data;

  assign ovr_set = byte_strobe & valid & ~pop;
  assign rd_data = {8'h00, data};
  assign cnt     = 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (byte_strobe && (!valid || pop)) begin
      data  <= rx_byte;
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
`endif

  assign rx_irq = valid;

  // set has priority over a same-edge write-1-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovr_set)                 ovr  <= 1'b1;
      else if (clr && bus.d_in[2]) ovr  <= 1'b0;
      if (ferr_strobe)             ferr <= 1'b1;
      else if (clr && bus.d_in[1]) ferr <= 1'b0;
    end
  end

  always_comb begin
    status              = '0;
    status[ST_VALID]    = valid;
    status[ST_FERR]     = ferr;
    status[ST_OVR]      = ovr;
    status[ST_BUSY]     = busy;
    status[ST_CNT +: 3] = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.d_out <= '0;
    end else if (rd_en) begin
      unique case (1'b1)
        (bus.addr == UART_ADDR_DATA):   bus.d_out <= rd_data;
        (bus.addr == UART_ADDR_STATUS): bus.d_out <= status;
        default:                        bus.d_out <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Randomized self-checking bench for peripheral_uart_rx against a
// transaction-level model of the receive buffer and status flags.
module tb_peripheral_uart_rx;

  localparam int CLK_FREQ = 3200000;
  localparam int BAUD     = 50000;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CLKS = 16 * DIV;
  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic rx_irq;
  int   n_chk = 0;
  int   n_err = 0;

  peripheral_uart_rx_if bus ();

  peripheral_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .uart_rx (uart_rx),
    .rx_irq  (rx_irq)
  );

  always #5 clk = ~clk;

  // reference model of what the CPU should observe
  bit         m_valid, m_ovr, m_ferr;
  logic [7:0] m_data;
  logic [7:0] m_q[$];

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = 8'h00;
    m_q.delete();
  endfunction

  function automatic bit model_has();
`ifdef UART_RX_FIFO_EN
    return m_q.size() != 0;
`else
    return m_valid;
`endif
  endfunction

  function automatic void model_frame(logic [7:0] b, bit stop_ok);
    if (!stop_ok) begin
      m_ferr = 1;
      return;
    end
`ifdef UART_RX_FIFO_EN
    if (m_q.size() == 4) m_ovr = 1;
    else m_q.push_back(b);
`else
    if (m_valid) m_ovr = 1;
    else begin m_valid = 1; m_data = b; end
`endif
  endfunction

  function automatic logic [15:0] model_pop();
`ifdef UART_RX_FIFO_EN
    if (m_q.size() == 0) return 16'h0000;
    return {8'h00, m_q.pop_front()};
`else
    m_valid = 0;
    return {8'h00, m_data};
`endif
  endfunction

  function automatic logic [15:0] model_status(bit busy);
    int c;
`ifdef UART_RX_FIFO_EN
    c = m_q.size();
`else
    c = 0;
`endif
    return {9'd0, 3'(c), busy, m_ovr, m_ferr, model_has()};
  endfunction

  function automatic void model_w1c(logic [15:0] d);
    if (d[2]) m_ovr = 0;
    if (d[1]) m_ferr = 0;
  endfunction

  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.cs = 1; bus.rd = 1; bus.addr = a;
    @(negedge clk);
    v = bus.d_out;
    bus.cs = 0; bus.rd = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cs = 1; bus.wr = 1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.cs = 0; bus.wr = 0;
  endtask

  task automatic rd_chk(string tag, logic [3:0] a);
    logic [15:0] v, e;
    bus_read(a, v);
    if (a == A_DATA)      e = model_pop();
    else if (a == A_STAT) e = model_status(1'b0);
    else                  e = 16'h0000;
    check(tag, v, e);
  endtask

  task automatic irq_chk(string tag);
    check(tag, {15'd0, rx_irq}, {15'd0, model_has()});
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++)
      if (model_has()) rd_chk("drain", A_DATA);
    bus_write(A_STAT, 16'h0006);
    model_w1c(16'h0006);
  endtask

  logic [15:0] v, e;
  logic [7:0]  rb;
  bit          sok;
  bit          seen;

  initial begin
    bus.cs = 0; bus.rd = 0; bus.wr = 0;
    bus.addr = 4'h0; bus.d_in = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    check("rst_dout", bus.d_out, 16'h0000);
    irq_chk("rst_irq");
    bus_read(A_STAT, v);
    check("rst_stat", v, 16'h0000);

    send_frame(8'h26, 1);
    model_frame(8'h26, 1);
    irq_chk("single_irq");
    rd_chk("single_stat", A_STAT);
    bus_read(A_DATA, v);
    check("single_data", v, 16'h0026);
    void'(model_pop());
    rd_chk("single_stat2", A_STAT);

    send_frame(8'h26, 1); model_frame(8'h26, 1);
    send_frame(8'h2D, 1); model_frame(8'h2D, 1);
    rd_chk("b2b_data", A_DATA);
    rd_chk("b2b_stat", A_STAT);
`ifndef UART_RX_FIFO_EN
    check("b2b_ovr", {15'd0, m_ovr}, 16'h0001);
`endif
    bus_write(A_STAT, 16'h0004); model_w1c(16'h0004);
    rd_chk("ovr_clr", A_STAT);
    drain();

    send_frame(8'h55, 0); model_frame(8'h55, 0);
    bus_read(A_STAT, v);
    check("ferr_stat", v, 16'h0002);
    bus_write(A_STAT, 16'h0002); model_w1c(16'h0002);
    rd_chk("ferr_clr", A_STAT);

    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    rd_chk("glitch_stat", A_STAT);
    irq_chk("glitch_irq");

    send_frame(8'h26, 1); model_frame(8'h26, 1);
    seen = 0;
    fork
      send_frame(8'h2D, 1);
      begin
        for (int i = 0; i < 20 * BIT_CLKS && !seen; i++) begin
          @(negedge clk);
          if (dut.u_core.byte_strobe) seen = 1;
        end
        if (seen) begin
          bus.cs = 1; bus.rd = 1; bus.addr = A_DATA;
          @(negedge clk);
          v = bus.d_out;
          bus.cs = 0; bus.rd = 0;
        end
      end
    join
    check("pd_seen", {15'd0, seen}, 16'h0001);
    e = model_pop();
    model_frame(8'h2D, 1);
    check("pd_old", v, e);
    irq_chk("pd_irq");
    bus_read(A_DATA, v);
    check("pd_new", v, 16'h002D);
    void'(model_pop());
    rd_chk("pd_stat", A_STAT);

`ifdef UART_RX_FIFO_EN
    drain();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1);
      model_frame(8'(i), 1);
    end
    bus_read(A_STAT, v);
    check("fifo_stat", v, 16'h0045);
    for (int i = 1; i <= 4; i++) begin
      bus_read(A_DATA, v);
      check("fifo_data", v, 16'(i));
      void'(model_pop());
    end
    bus_read(A_DATA, v);
    check("fifo_empty", v, 16'h0000);
    drain();
`endif

    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    bus_read(A_STAT, v);
    check("mid_busy", v, model_status(1'b1));
    @(negedge clk);
    rst = 1; uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    repeat (3 * BIT_CLKS) @(negedge clk);
    rd_chk("mid_rst_stat", A_STAT);
    irq_chk("mid_rst_irq");

    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      sok = ($urandom_range(0, 5) != 0);
      send_frame(rb, sok);
      model_frame(rb, sok);
      irq_chk("rnd_irq");
      if ($urandom_range(0, 1) == 1) rd_chk("rnd_stat", A_STAT);
      repeat ($urandom_range(0, 2)) rd_chk("rnd_data", A_DATA);
      if ($urandom_range(0, 3) == 0) begin
        v = 16'($urandom_range(0, 7));
        bus_write(A_STAT, v);
        model_w1c(v);
      end
      if ($urandom_range(0, 5) == 0) begin
        bus_write(A_DATA, 16'hFFFF);
        rd_chk("rnd_other", 4'h5);
      end
    end
    rd_chk("final_stat", A_STAT);
    irq_chk("final_irq");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
